// File: rtl/usb_fs_rx_phy.sv
// USB full-speed receive front end.
// Samples D+/D- at 48 MHz (4x the 12 Mbps bit rate) and recovers bit timing
// from line edges. Performs NRZI decode, SYNC detection, bit-unstuffing and
// EOP detection, and hands LSB-first bytes plus packet strobes downstream.
// Handshake: rx_valid is a one-cycle push with no back-pressure; rx_data is
// valid in that cycle and holds until the next rx_valid. pkt_start, pkt_end
// and rx_err are one-cycle strobes. rx_active frames a packet in progress.
// dbg_state exposes the receive FSM (0 = IDLE, 1 = SYNC, 2 = DATA, 3 = EOP).
module usb_fs_rx_phy #(
   parameter int SYNC_STAGES  = 2,
   parameter int SAMPLE_PHASE = 2
) (
   input  logic       clk_48mhz,
   input  logic       reset,
   input  logic       usb_p_rx,
   input  logic       usb_n_rx,
   input  logic       rx_en,
   output logic       pkt_start,
   output logic       pkt_end,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       rx_active,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] LINE_J     = 2'b10;
   localparam logic [1:0] LINE_K     = 2'b01;
   localparam logic [1:0] LINE_SE0   = 2'b00;
   localparam logic [1:0] LINE_SE1   = 2'b11;
   localparam logic [1:0] LP_PHASE   = 2'(SAMPLE_PHASE);
   // Decoded SYNC in time order: seven 0s then a 1 (oldest bit in [7]).
   localparam logic [7:0] SYNC_MATCH = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_EOP  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_p_sync;
   logic [SYNC_STAGES-1:0] r_n_sync;
   logic [1:0]             r_line_q;
   logic [1:0]             r_phase;
   logic [1:0]             r_prev_line;
   state_t                 r_state;
   logic [7:0]             r_sync_sr;
   logic [3:0]             r_sync_cnt;
   logic [7:0]             r_byte;
   logic [2:0]             r_bit_cnt;
   logic [2:0]             r_ones;
   logic                   r_pkt_start;
   logic                   r_pkt_end;
   logic [7:0]             r_rx_data;
   logic                   r_rx_valid;
   logic                   r_rx_err;
   logic                   r_rx_active;

   logic [1:0] w_line;
   logic       w_edge;
   logic       w_strobe;
   logic       w_is_jk;
   logic       w_bit;
   logic [7:0] w_sr_next;
   logic [7:0] w_byte_next;

   // Synchronized line; the bit sampled at a strobe is the registered copy
   // so that it is taken two clocks after the most recent edge.
   assign w_line      = {r_p_sync[SYNC_STAGES-1], r_n_sync[SYNC_STAGES-1]};
   assign w_edge      = (w_line != r_line_q) && (w_line != LINE_SE1) &&
                        (r_line_q != LINE_SE1);
   assign w_strobe    = (r_phase == LP_PHASE);
   assign w_is_jk     = (r_line_q == LINE_J) || (r_line_q == LINE_K);
   assign w_bit       = (r_line_q == r_prev_line);
   assign w_sr_next   = {r_sync_sr[6:0], w_bit};
   assign w_byte_next = {w_bit, r_byte[7:1]};

   assign pkt_start = r_pkt_start;
   assign pkt_end   = r_pkt_end;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign rx_err    = r_rx_err;
   assign rx_active = r_rx_active;
   assign dbg_state = r_state;

   // Metastability synchronizer for the raw pad inputs; resets to idle J.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         r_p_sync <= '1;
         r_n_sync <= '0;
      end else begin
         r_p_sync <= {r_p_sync[SYNC_STAGES-2:0], usb_p_rx};
         r_n_sync <= {r_n_sync[SYNC_STAGES-2:0], usb_n_rx};
      end
   end

   // Bit clock recovery: free-running phase, realigned on every line edge.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         r_line_q <= LINE_J;
         r_phase  <= 2'd0;
      end else begin
         r_line_q <= w_line;
         r_phase  <= w_edge ? 2'd0 : r_phase + 2'd1;
      end
   end

   // Receive FSM: SYNC hunt, unstuffing, byte assembly and EOP handling.
   always_ff @(posedge clk_48mhz) begin
      r_pkt_start <= 1'b0;
      r_pkt_end   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
      if (reset) begin
         r_state     <= ST_IDLE;
         r_prev_line <= LINE_J;
         r_sync_sr   <= 8'h00;
         r_sync_cnt  <= 4'd0;
         r_byte      <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_ones      <= 3'd0;
         r_rx_data   <= 8'h00;
         r_rx_active <= 1'b0;
      end else begin
         // NRZI reference tracks the bus even while reception is disabled.
         if (w_strobe && w_is_jk) begin
            r_prev_line <= r_line_q;
         end
         if (!rx_en) begin
            r_state     <= ST_IDLE;
            r_rx_active <= 1'b0;
         end else if (w_strobe) begin
            case (r_state)
               ST_IDLE: begin
                  if (r_line_q == LINE_K) begin
                     // First K decodes as 0 against idle J; older bits
                     // preset to 1 so they can never complete a match.
                     r_state    <= ST_SYNC;
                     r_sync_sr  <= 8'hFE;
                     r_sync_cnt <= 4'd0;
                  end
               end
               ST_SYNC: begin
                  if (r_line_q == LINE_SE1) begin
                     r_rx_err <= 1'b1;
                     r_state  <= ST_IDLE;
                  end else if (r_line_q == LINE_SE0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_sync_sr <= w_sr_next;
                     if (w_sr_next == SYNC_MATCH) begin
                        // Stuffing run restarts at the first data bit.
                        r_pkt_start <= 1'b1;
                        r_rx_active <= 1'b1;
                        r_bit_cnt   <= 3'd0;
                        r_ones      <= 3'd0;
                        r_state     <= ST_DATA;
                     end else if (r_sync_cnt == 4'd15) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_sync_cnt <= r_sync_cnt + 4'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (r_line_q == LINE_SE1) begin
                     r_rx_err    <= 1'b1;
                     r_rx_active <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else if (r_line_q == LINE_SE0) begin
                     r_state <= ST_EOP;
                  end else if (r_ones == 3'd6) begin
                     // Stuff bit position: a 0 is dropped, a 1 is fatal.
                     if (w_bit) begin
                        r_rx_err    <= 1'b1;
                        r_rx_active <= 1'b0;
                        r_state     <= ST_IDLE;
                     end else begin
                        r_ones <= 3'd0;
                     end
                  end else begin
                     r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
                     r_byte    <= w_byte_next;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_rx_data  <= w_byte_next;
                        r_rx_valid <= 1'b1;
                     end
                  end
               end
               ST_EOP: begin
                  if (r_line_q == LINE_J) begin
                     // Seven leftover bits is the tolerated dribble case.
                     r_pkt_end   <= 1'b1;
                     r_rx_err    <= (r_bit_cnt != 3'd0) && (r_bit_cnt != 3'd7);
                     r_rx_active <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else if (r_line_q != LINE_SE0) begin
                     // K or SE1 after SE0 aborts the packet.
                     r_rx_err    <= 1'b1;
                     r_rx_active <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Bench for usb_fs_rx_phy: a line encoder builds NRZI/stuffed bit-cell
// sequences from packet contents, and a monitor scoreboards the received
// bytes and strobes against what each packet should produce.
module tb_usb_fs_rx_phy;

   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] SE1 = 2'b11;

   logic       clk_48mhz = 1'b0;
   logic       reset;
   logic       usb_p_rx;
   logic       usb_n_rx;
   logic       rx_en;
   logic       pkt_start;
   logic       pkt_end;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_active;
   logic [1:0] dbg_state;

   usb_fs_rx_phy #(.SYNC_STAGES(2), .SAMPLE_PHASE(2)) dut (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .usb_p_rx  (usb_p_rx),
      .usb_n_rx  (usb_n_rx),
      .rx_en     (rx_en),
      .pkt_start (pkt_start),
      .pkt_end   (pkt_end),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err),
      .rx_active (rx_active),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #10 clk_48mhz = ~clk_48mhz;

   // ---------------- scoreboard state ----------------
   int         n_vec  = 0;
   int         n_miss = 0;
   logic [7:0] exp_q[$];
   int         got_start, got_end, got_err, got_valid;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts strobes and checks every delivered byte in order.
   always @(negedge clk_48mhz) begin
      if (pkt_start === 1'b1) got_start++;
      if (pkt_end === 1'b1)   got_end++;
      if (rx_err === 1'b1)    got_err++;
      if (rx_valid === 1'b1) begin
         got_valid++;
         check("valid_while_active", int'(rx_active), 1);
         check("valid_not_with_start", int'(pkt_start), 0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
         end else begin
            check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- line encoder (reference model) ----------------
   logic [1:0] line_q[$];
   logic [1:0] tx_lvl;
   int         tx_ones;
   bit         tx_alt;

   task automatic push_nrzi(input bit b);
      if (!b) tx_lvl = (tx_lvl == J) ? K : J;
      line_q.push_back(tx_lvl);
   endtask

   task automatic push_data_bit(input bit b);
      push_nrzi(b);
      tx_ones = b ? tx_ones + 1 : 0;
      if (tx_ones == 6) begin
         push_nrzi(1'b0);
         tx_ones = 0;
      end
   endtask

   task automatic build_sync();
      line_q.delete();
      tx_lvl  = J;
      tx_ones = 0;
      for (int i = 0; i < 7; i++) push_nrzi(1'b0);
      push_nrzi(1'b1);
   endtask

   task automatic build_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) push_data_bit(b[i]);
   endtask

   task automatic build_eop();
      line_q.push_back(SE0);
      line_q.push_back(SE0);
      for (int i = 0; i < 4; i++) line_q.push_back(J);
   endtask

   // ---------------- driver ----------------
   task automatic drive_range(input int from, input int to, input bit jit);
      int per;
      for (int i = from; i < to; i++) begin
         {usb_p_rx, usb_n_rx} = line_q[i];
         per    = jit ? (tx_alt ? 5 : 3) : 4;
         tx_alt = ~tx_alt;
         repeat (per) @(negedge clk_48mhz);
      end
   endtask

   task automatic idle_bits(input int n);
      {usb_p_rx, usb_n_rx} = J;
      repeat (4 * n) @(negedge clk_48mhz);
   endtask

   task automatic clear_counts();
      got_start = 0;
      got_end   = 0;
      got_err   = 0;
      got_valid = 0;
      exp_q.delete();
   endtask

   task automatic check_counts(input string tag, input int s, input int v,
                               input int e, input int r);
      check({tag, "_pkt_start"}, got_start, s);
      check({tag, "_rx_valid"}, got_valid, v);
      check({tag, "_pkt_end"}, got_end, e);
      check({tag, "_rx_err"}, got_err, r);
      check({tag, "_bytes_left"}, exp_q.size(), 0);
      check({tag, "_rx_active"}, int'(rx_active), 0);
      check({tag, "_idle_state"}, int'(dbg_state), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      int          nbytes;
      logic [31:0] data;     // byte i in data[8*i +: 8]
      int          extra;    // trailing bits beyond whole bytes
      logic [6:0]  extra_pat;
      bit          jit;
      int          exp_valid;
      int          exp_end;
      int          exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic run_packet(input string name, input int nbytes,
                             input logic [31:0] data, input int extra,
                             input logic [6:0] extra_pat, input bit jit,
                             input int exp_valid, input int exp_end,
                             input int exp_err);
      clear_counts();
      build_sync();
      for (int i = 0; i < nbytes; i++) begin
         build_byte(data[8*i +: 8]);
         exp_q.push_back(data[8*i +: 8]);
      end
      for (int i = 0; i < extra; i++) push_data_bit(extra_pat[i]);
      build_eop();
      tx_alt = 1'b0;
      drive_range(0, line_q.size(), jit);
      idle_bits(6);
      check_counts(name, 1, exp_valid, exp_end, exp_err);
      if (nbytes > 0) check({name, "_rx_data_hold"}, int'(rx_data),
                            int'(data[8*(nbytes-1) +: 8]));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{"a5",       1, 32'h000000A5, 0, 7'h00, 1'b0, 1, 1, 0};
      vecs[1] = '{"ff_ff",    2, 32'h0000FFFF, 0, 7'h00, 1'b0, 2, 1, 0};
      vecs[2] = '{"jitter",   2, 32'h0000C35A, 0, 7'h00, 1'b1, 2, 1, 0};
      vecs[3] = '{"3c",       1, 32'h0000003C, 0, 7'h00, 1'b0, 1, 1, 0};
      vecs[4] = '{"partial",  1, 32'h00000012, 3, 7'h05, 1'b0, 1, 1, 1};
      vecs[5] = '{"dribble",  1, 32'h00000081, 7, 7'h35, 1'b0, 1, 1, 0};
      vecs[6] = '{"empty",    0, 32'h00000000, 0, 7'h00, 1'b0, 0, 1, 0};
      vecs[7] = '{"deadbeef", 4, 32'hDEADBEEF, 0, 7'h00, 1'b1, 4, 1, 0};
      vecs[8] = '{"ones_run", 3, 32'h007FFFFE, 0, 7'h00, 1'b0, 3, 1, 0};

      // clock/reset
      reset = 1'b1;
      rx_en = 1'b1;
      {usb_p_rx, usb_n_rx} = J;
      tx_alt = 1'b0;
      clear_counts();
      repeat (4) @(negedge clk_48mhz);
      check("rst_pkt_start", int'(pkt_start), 0);
      check("rst_pkt_end", int'(pkt_end), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_rx_err", int'(rx_err), 0);
      check("rst_rx_active", int'(rx_active), 0);
      check("rst_rx_data", int'(rx_data), 0);
      check("rst_state", int'(dbg_state), 0);
      reset = 1'b0;

      // idle J for 1000 clocks
      clear_counts();
      idle_bits(250);
      check("idle_pkt_start", got_start, 0);
      check_counts("idle", 0, 0, 0, 0);

      // table-driven packets
      for (int i = 0; i < 9; i++) begin
         run_packet(vecs[i].name, vecs[i].nbytes, vecs[i].data, vecs[i].extra,
                    vecs[i].extra_pat, vecs[i].jit, vecs[i].exp_valid,
                    vecs[i].exp_end, vecs[i].exp_err);
      end

      // seven decoded 1s after SYNC: stuff error, then a clean packet
      clear_counts();
      build_sync();
      for (int i = 0; i < 7; i++) push_nrzi(1'b1);
      tx_alt = 1'b0;
      drive_range(0, line_q.size(), 1'b0);
      idle_bits(30);
      check_counts("stuff_err", 1, 0, 0, 1);
      run_packet("after_err", 1, 32'h3C, 0, 7'h00, 1'b0, 1, 1, 0);

      // SE1 inside a packet
      clear_counts();
      build_sync();
      build_byte(8'h55);
      exp_q.push_back(8'h55);
      line_q.push_back(SE1);
      line_q.push_back(SE1);
      tx_alt = 1'b0;
      drive_range(0, line_q.size(), 1'b0);
      idle_bits(30);
      check_counts("se1", 1, 1, 0, 1);

      // synchronous reset in the middle of the first data byte
      clear_counts();
      build_sync();
      build_byte(8'hA5);
      build_byte(8'h11);
      build_eop();
      tx_alt = 1'b0;
      drive_range(0, 12, 1'b0);
      check("mid_rst_active_before", int'(rx_active), 1);
      reset = 1'b1;
      @(negedge clk_48mhz);
      check("mid_rst_pkt_start", int'(pkt_start), 0);
      check("mid_rst_pkt_end", int'(pkt_end), 0);
      check("mid_rst_rx_valid", int'(rx_valid), 0);
      check("mid_rst_rx_err", int'(rx_err), 0);
      check("mid_rst_rx_data", int'(rx_data), 0);
      reset = 1'b0;
      clear_counts();
      idle_bits(40);
      check_counts("mid_rst", 0, 0, 0, 0);

      // rx_en dropped mid-packet and held low through EOP
      clear_counts();
      build_sync();
      build_byte(8'hA5);
      build_byte(8'hC3);
      build_eop();
      tx_alt = 1'b0;
      drive_range(0, 11, 1'b0);
      check("rx_en_active_before", int'(rx_active), 1);
      rx_en = 1'b0;
      @(negedge clk_48mhz);
      check("rx_en_active_dropped", int'(rx_active), 0);
      drive_range(11, line_q.size(), 1'b0);
      idle_bits(10);
      rx_en = 1'b1;
      idle_bits(30);
      check_counts("rx_en_low", 1, 0, 0, 0);

      // randomized packets
      for (int n = 0; n < 12; n++) begin
         int          len;
         logic [31:0] d;
         bit          jit;
         len = $urandom_range(1, 4);
         d   = $urandom;
         jit = 1'($urandom_range(0, 1));
         run_packet($sformatf("rand%0d", n), len, d, 0, 7'h00, jit,
                    len, 1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
